// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the SRAM write scheduler.
// No logic; the FSM state encoding and counter width live here.
// Imported by the arbiter and the scheduler top.
package sram_sched_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int CONFLICT_CNT_W = 16;

endpackage

// File: rtl/sram_wr_arb.sv
// Rotating-priority same-address arbiter across NUM_REQ write requesters.
// Purely combinational, zero latency.
// Losers are not granted; the caller holds them and advances the pointer.
module sram_wr_arb
   import sram_sched_pkg::*;
#(
   parameter int NUM_REQ    = 8,
   parameter int SRAM_INDEX = 4,
   parameter int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]            i_valid,
   input  logic [NUM_REQ*SRAM_INDEX-1:0] i_addr,
   input  logic [PTR_W-1:0]              i_prio_ptr,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic                          o_any_loss
);

   logic [NUM_REQ-1:0] w_grant;

   // Distance from the priority pointer; smaller means higher priority.
   function automatic int f_rank(input int idx, input int ptr);
      return (idx + NUM_REQ - ptr) % NUM_REQ;
   endfunction

   // A valid request wins unless a higher-priority valid request targets the same address.
   always_comb begin
      w_grant = i_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if ((j != i) && i_valid[j] &&
                (i_addr[j*SRAM_INDEX +: SRAM_INDEX] == i_addr[i*SRAM_INDEX +: SRAM_INDEX]) &&
                (f_rank(j, int'(i_prio_ptr)) < f_rank(i, int'(i_prio_ptr)))) begin
               w_grant[i] = 1'b0;
            end
         end
      end
   end

   assign o_grant    = w_grant;
   assign o_any_loss = |(i_valid & ~w_grant);

endmodule

// File: rtl/sram_wr_sched.sv
// Write scheduler/initialiser for an 8-write-port SRAM: clears it, then arbitrates same-address writes.
// Accepted write appears on we_o/addrwr_o/datawr_o one cycle after acceptance.
// ready is combinational per requester; all-zero during INIT, losers wait for a later grant.
module sram_wr_sched
   import sram_sched_pkg::*;
#(
   parameter int                    SRAM_DEPTH = 16,
   parameter int                    SRAM_INDEX = 4,
   parameter int                    SRAM_WIDTH = 8,
   parameter int                    NUM_REQ    = 8,
   parameter logic [SRAM_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*SRAM_INDEX-1:0] req_addr_i,
   input  logic [NUM_REQ*SRAM_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_REQ-1:0]            we_o,
   output logic [NUM_REQ*SRAM_INDEX-1:0] addrwr_o,
   output logic [NUM_REQ*SRAM_WIDTH-1:0] datawr_o,
   output logic                          init_done_o,
   output logic [CONFLICT_CNT_W-1:0]     conflict_cnt_o
);

   localparam int                    PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [SRAM_INDEX-1:0] INIT_LAST = SRAM_INDEX'(SRAM_DEPTH - NUM_REQ);
   localparam logic [SRAM_INDEX-1:0] INIT_STEP = SRAM_INDEX'(NUM_REQ);
   localparam logic [PTR_W-1:0]      PRIO_LAST = PTR_W'(NUM_REQ - 1);

   state_t                        r_state;
   logic                          r_init_done;
   logic [SRAM_INDEX-1:0]         r_init_ptr;
   logic [PTR_W-1:0]              r_prio_ptr;
   logic [CONFLICT_CNT_W-1:0]     r_conflict_cnt;
   logic [NUM_REQ-1:0]            r_we;
   logic [NUM_REQ*SRAM_INDEX-1:0] r_addr;
   logic [NUM_REQ*SRAM_WIDTH-1:0] r_data;

   logic [NUM_REQ-1:0]            w_grant;
   logic                          w_any_loss;
   logic                          w_run;
   logic                          w_loss;

   sram_wr_arb #(
      .NUM_REQ    (NUM_REQ),
      .SRAM_INDEX (SRAM_INDEX),
      .PTR_W      (PTR_W)
   ) u_arb (
      .i_valid    (req_valid_i),
      .i_addr     (req_addr_i),
      .i_prio_ptr (r_prio_ptr),
      .o_grant    (w_grant),
      .o_any_loss (w_any_loss)
   );

   assign w_run       = (r_state == RUN);
   assign w_loss      = w_run & w_any_loss;
   assign req_ready_o = w_run ? w_grant : '0;

   // Init/run FSM: sweep the SRAM in NUM_REQ-entry strides, restart the sweep on flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= INIT;
         r_init_done <= 1'b0;
         r_init_ptr  <= '0;
      end else begin
         case (r_state)
            INIT: begin
               if (flush_i) begin
                  r_init_ptr <= '0;
               end else if (r_init_ptr == INIT_LAST) begin
                  r_state     <= RUN;
                  r_init_done <= 1'b1;
                  r_init_ptr  <= '0;
               end else begin
                  r_init_ptr <= r_init_ptr + INIT_STEP;
               end
            end
            RUN: begin
               if (flush_i) begin
                  r_state     <= INIT;
                  r_init_done <= 1'b0;
                  r_init_ptr  <= '0;
               end
            end
            default: begin
               r_state     <= INIT;
               r_init_done <= 1'b0;
               r_init_ptr  <= '0;
            end
         endcase
      end
   end

   // SRAM write-port registers: init stripe in INIT, granted requests in RUN; ungranted ports keep addr/data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we   <= '0;
         r_addr <= '0;
         r_data <= '0;
      end else if (!w_run) begin
         r_we <= '1;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_addr[i*SRAM_INDEX +: SRAM_INDEX] <= r_init_ptr + SRAM_INDEX'(i);
            r_data[i*SRAM_WIDTH +: SRAM_WIDTH] <= INIT_VALUE;
         end
      end else begin
         r_we <= w_grant;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
               r_addr[i*SRAM_INDEX +: SRAM_INDEX] <= req_addr_i[i*SRAM_INDEX +: SRAM_INDEX];
               r_data[i*SRAM_WIDTH +: SRAM_WIDTH] <= req_data_i[i*SRAM_WIDTH +: SRAM_WIDTH];
            end
         end
      end
   end

   // Rotate priority and count (saturating) every cycle in which some valid request lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prio_ptr     <= '0;
         r_conflict_cnt <= '0;
      end else if (w_loss) begin
         r_prio_ptr <= (r_prio_ptr == PRIO_LAST) ? '0 : r_prio_ptr + PTR_W'(1);
         if (r_conflict_cnt != '1) begin
            r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_W'(1);
         end
      end
   end

   assign we_o           = r_we;
   assign addrwr_o       = r_addr;
   assign datawr_o       = r_data;
   assign init_done_o    = r_init_done;
   assign conflict_cnt_o = r_conflict_cnt;

endmodule

// File: tb/tb_sram_wr_sched.sv
// Directed bench for sram_wr_sched at default parameters.
// Outputs sampled at the falling edge, inputs driven there too.
// Also watches that the stimulus never withdraws an ungranted request.
module tb_sram_wr_sched;

   localparam int NR = 8;
   localparam int AW = 4;
   localparam int DW = 8;

   logic             clk;
   logic             reset;
   logic             flush_i;
   logic [NR-1:0]    req_valid_i;
   logic [NR*AW-1:0] req_addr_i;
   logic [NR*DW-1:0] req_data_i;
   logic [NR-1:0]    req_ready_o;
   logic [NR-1:0]    we_o;
   logic [NR*AW-1:0] addrwr_o;
   logic [NR*DW-1:0] datawr_o;
   logic             init_done_o;
   logic [15:0]      conflict_cnt_o;

   logic [AW-1:0] a [NR];
   logic [DW-1:0] d [NR];
   logic [NR-1:0] pend;
   logic [NR-1:0] rdy_snap;
   int n_vec;
   int n_err;

   sram_wr_sched dut (
      .clk            (clk),
      .reset          (reset),
      .flush_i        (flush_i),
      .req_valid_i    (req_valid_i),
      .req_addr_i     (req_addr_i),
      .req_data_i     (req_data_i),
      .req_ready_o    (req_ready_o),
      .we_o           (we_o),
      .addrwr_o       (addrwr_o),
      .datawr_o       (datawr_o),
      .init_done_o    (init_done_o),
      .conflict_cnt_o (conflict_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_addr_i = '0;
      req_data_i = '0;
      for (int i = 0; i < NR; i++) begin
         req_addr_i[i*AW +: AW] = a[i];
         req_data_i[i*DW +: DW] = d[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Requester contract: a valid that was not granted must still be valid next edge.
   always @(posedge clk) begin
      if (!reset) begin
         pend <= '0;
      end else begin
         if (pend != '0) chk("hold_valid", 64'(pend & ~req_valid_i), 64'h0);
         pend <= req_valid_i & ~req_ready_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      flush_i = 1'b0;
      req_valid_i = '0;
      for (int i = 0; i < NR; i++) begin
         a[i] = AW'(i);
         d[i] = DW'(8'h10 + i);
      end
      #1 reset = 1'b0;
      #1;
      chk("rst_we", 64'(we_o), 64'h0);
      chk("rst_addr", 64'(addrwr_o), 64'h0);
      chk("rst_data", datawr_o, 64'h0);
      chk("rst_ready", 64'(req_ready_o), 64'h0);
      chk("rst_done", 64'(init_done_o), 64'h0);
      chk("rst_cnt", 64'(conflict_cnt_o), 64'h0);

      // Release reset with all requesters waiting on distinct addresses 0..7.
      @(negedge clk);
      @(negedge clk);
      req_valid_i = 8'hFF;
      reset = 1'b1;
      #1 chk("init0_ready", 64'(req_ready_o), 64'h0);
      tick();
      chk("init1_we", 64'(we_o), 64'hFF);
      chk("init1_addr", 64'(addrwr_o), 64'h7654_3210);
      chk("init1_data", datawr_o, 64'h0);
      chk("init1_done", 64'(init_done_o), 64'h0);
      #1 chk("init1_ready", 64'(req_ready_o), 64'h0);
      tick();
      chk("init2_we", 64'(we_o), 64'hFF);
      chk("init2_addr", 64'(addrwr_o), 64'hFEDC_BA98);
      chk("init2_data", datawr_o, 64'h0);
      chk("init2_done", 64'(init_done_o), 64'h1);
      #1 chk("dist_ready", 64'(req_ready_o), 64'hFF);
      tick();
      chk("dist_we", 64'(we_o), 64'hFF);
      chk("dist_addr", 64'(addrwr_o), 64'h7654_3210);
      chk("dist_data", datawr_o, 64'h1716_1514_1312_1110);
      chk("dist_cnt", 64'(conflict_cnt_o), 64'h0);
      req_valid_i = '0;
      #1 chk("idle_ready", 64'(req_ready_o), 64'h0);
      tick();
      chk("idle_we", 64'(we_o), 64'h0);
      chk("idle_addr_hold", 64'(addrwr_o), 64'h7654_3210);

      // Requesters 2 and 5 collide at address 3 with prio_ptr 0.
      a[2] = 4'h3; d[2] = 8'hA2;
      a[5] = 4'h3; d[5] = 8'hB5;
      req_valid_i = 8'h24;
      #1 chk("coll_ready", 64'(req_ready_o), 64'h04);
      tick();
      chk("coll_we", 64'(we_o), 64'h04);
      chk("coll_addr", 64'(addrwr_o), 64'h7654_3310);
      chk("coll_data", datawr_o, 64'h1716_1514_13A2_1110);
      chk("coll_cnt", 64'(conflict_cnt_o), 64'h1);
      req_valid_i = 8'h20;
      #1 chk("retry_ready", 64'(req_ready_o), 64'h20);
      tick();
      chk("retry_we", 64'(we_o), 64'h20);
      chk("retry_addr", 64'(addrwr_o), 64'h7634_3310);
      chk("retry_data", datawr_o, 64'h1716_B514_13A2_1110);
      chk("retry_cnt", 64'(conflict_cnt_o), 64'h1);
      req_valid_i = '0;

      // All eight at address 7; prio_ptr starts at 1, so winners go 1,2,..,7,0.
      for (int i = 0; i < NR; i++) begin
         a[i] = 4'h7;
         d[i] = DW'(8'h40 + i);
      end
      req_valid_i = 8'hFF;
      for (int k = 0; k < NR; k++) begin
         logic [7:0] one;
         one = 8'h01;
         #1 chk("rot_ready", 64'(req_ready_o), 64'(one << ((k + 1) % NR)));
         tick();
         chk("rot_we", 64'(we_o), 64'(one << ((k + 1) % NR)));
         chk("rot_cnt", 64'(conflict_cnt_o), 64'(2 + k));
      end
      chk("rot_addr", 64'(addrwr_o), 64'h7777_7777);
      chk("rot_data", datawr_o, 64'h4746_4544_4342_4140);

      // Drain: each requester withdraws only after its own grant.
      for (int n = 0; n < 10 && req_valid_i != '0; n++) begin
         #1 rdy_snap = req_ready_o;
         tick();
         req_valid_i = req_valid_i & ~rdy_snap;
      end
      chk("drain_done", 64'(req_valid_i), 64'h0);
      chk("drain_cnt", 64'(conflict_cnt_o), 64'd16);

      // Flush in RUN together with an accepted write of A5 to address 9.
      a[0] = 4'h9; d[0] = 8'hA5;
      req_valid_i = 8'h01;
      flush_i = 1'b1;
      #1 chk("fl_ready", 64'(req_ready_o), 64'h01);
      tick();
      flush_i = 1'b0;
      chk("fl_we", 64'(we_o), 64'h01);
      chk("fl_addr", 64'(addrwr_o), 64'h7777_7779);
      chk("fl_data", datawr_o, 64'h4746_4544_4342_41A5);
      chk("fl_done", 64'(init_done_o), 64'h0);
      a[0] = 4'hC; d[0] = 8'h33;
      #1 chk("fl_init0_ready", 64'(req_ready_o), 64'h0);
      tick();
      chk("fl_init1_we", 64'(we_o), 64'hFF);
      chk("fl_init1_addr", 64'(addrwr_o), 64'h7654_3210);
      chk("fl_init1_data", datawr_o, 64'h0);
      chk("fl_init1_done", 64'(init_done_o), 64'h0);
      #1 chk("fl_init1_ready", 64'(req_ready_o), 64'h0);
      tick();
      chk("fl_init2_we", 64'(we_o), 64'hFF);
      chk("fl_init2_addr", 64'(addrwr_o), 64'hFEDC_BA98);
      chk("fl_init2_done", 64'(init_done_o), 64'h1);
      #1 chk("fl_run_ready", 64'(req_ready_o), 64'h01);
      tick();
      chk("fl_run_we", 64'(we_o), 64'h01);
      chk("fl_run_addr", 64'(addrwr_o), 64'hFEDC_BA9C);
      chk("fl_run_data", datawr_o, 64'h33);

      // Asynchronous reset between edges while a write is on the ports.
      a[0] = 4'h5; d[0] = 8'h5A;
      tick();
      chk("pre_rst_we", 64'(we_o), 64'h01);
      #2 reset = 1'b0;
      #1;
      chk("arst_we", 64'(we_o), 64'h0);
      chk("arst_addr", 64'(addrwr_o), 64'h0);
      chk("arst_data", datawr_o, 64'h0);
      chk("arst_ready", 64'(req_ready_o), 64'h0);
      chk("arst_done", 64'(init_done_o), 64'h0);
      chk("arst_cnt", 64'(conflict_cnt_o), 64'h0);
      req_valid_i = '0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("reinit_we", 64'(we_o), 64'hFF);
      chk("reinit_addr", 64'(addrwr_o), 64'h7654_3210);
      chk("reinit_done", 64'(init_done_o), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_wr_sched.md
# sram_wr_sched

Write-side scheduler and initialiser for the multi-ported register/table SRAM (8 write ports). It accepts up to NUM_REQ write requests per cycle over valid/ready and resolves same-address collisions with a rotating-priority arbiter, because the SRAM itself silently resolves such collisions by highest port index. It drives the SRAM write ports from registered outputs, and it owns the SRAM clear sequence after reset or on flush, so the SRAM's own reset is tied inactive.

## Interface
- SRAM_DEPTH, 16, SRAM entries; must be a multiple of NUM_REQ.
- SRAM_INDEX, 4, address width, log2(SRAM_DEPTH).
- SRAM_WIDTH, 8, data width.
- NUM_REQ, 8, requesters; equals the SRAM write-port count; requester i maps permanently to write port i.
- INIT_VALUE, 0, value written to every entry during init.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush_i  in  1  pulse: re-run the init sequence.
- req_valid_i  in  NUM_REQ  per-requester write valid.
- req_addr_i  in  NUM_REQ*SRAM_INDEX  packed addresses; requester i at [i*SRAM_INDEX +: SRAM_INDEX].
- req_data_i  in  NUM_REQ*SRAM_WIDTH  packed data, same packing.
- req_ready_o  out  NUM_REQ  grant; a transfer occurs when valid and ready are both high.
- we_o  out  NUM_REQ  registered SRAM write enables.
- addrwr_o  out  NUM_REQ*SRAM_INDEX  registered SRAM write addresses.
- datawr_o  out  NUM_REQ*SRAM_WIDTH  registered SRAM write data.
- init_done_o  out  1  high in RUN.
- conflict_cnt_o  out  16  saturating count of cycles in which at least one valid request lost arbitration.

## Operation
- **States**
  - INIT: write INIT_VALUE to entries init_ptr .. init_ptr+NUM_REQ-1, one entry per port, all we_o high. init_ptr advances by NUM_REQ each cycle. When init_ptr == SRAM_DEPTH-NUM_REQ, the next state is RUN.
  - RUN: normal arbitration.
  - flush_i high in RUN → INIT, with init_ptr cleared to 0.
  - flush_i during INIT restarts the sequence at init_ptr = 0.
- **Ready in INIT:** req_ready_o is all zeros and no request is accepted.
- **Arbitration in RUN (combinational, this cycle)**
  - Requester i is granted iff req_valid_i[i] is high and no valid requester j with an equal address has higher priority.
  - Priority order is prio_ptr, prio_ptr+1, … modulo NUM_REQ.
  - Non-colliding requests are all granted in the same cycle.
- **Priority pointer:** prio_ptr increments by 1 (wrapping NUM_REQ-1 → 0) in any cycle with a losing valid request; otherwise it holds.
- **Starvation bound:** a continuously valid requester is granted within NUM_REQ cycles.
- **Output registers:** on each edge in RUN, we_o[i] ← grant[i] and addrwr_o/datawr_o[i] ← request i's address and data. When grant[i] is 0, addr/data hold their previous values.
- **Requester contract:** requesters hold valid, addr and data stable until ready. The bench flags a valid drop without a grant.
- **conflict_cnt_o:** +1 per losing cycle; saturates at 16'hFFFF; cleared only by reset.

## Timing
- ready is combinational from valid and addr in the same cycle (no registered path into ready).
- Write latency: an accepted request appears on we_o/addrwr_o/datawr_o on the next cycle; the SRAM commits it on the edge after that.
  - Read-after-write visibility is therefore 2 edges after acceptance.
  - Bypassing is the consumer's job.
- Init duration: SRAM_DEPTH/NUM_REQ cycles (2 at defaults). init_done_o rises the cycle after the last init write is issued.
- **Reset (asynchronous, active-low).** Output reset values:
  - we_o = 0, addrwr_o = 0, datawr_o = 0
  - req_ready_o = 0, init_done_o = 0
  - conflict_cnt_o = 0
- **Reset (asynchronous, active-low).** Internal state after reset: state INIT, init_ptr 0, prio_ptr 0. INIT starts on the first edge after deassertion.
- **Reset mid-operation:** pending output writes are dropped and the SRAM is re-cleared by the init sequence.
- **Flush with an accepted write:** a write accepted in the same cycle flush_i is sampled is still issued. The INIT writes that follow overwrite it.

## Structure
- Shared package sram_sched_pkg holds the state enum (INIT, RUN) and the counter width constant CONFLICT_CNT_W = 16.
- One sub-module, sram_wr_arb: purely combinational rotating-priority same-address arbiter. Inputs valid/addr/prio_ptr; outputs grant and any_loss.
- The top level holds the FSM, init_ptr, prio_ptr, the output registers and the counter.

## Test plan
- Reset release, no requests: we_o=8'hFF for 2 cycles with addresses 0–7 then 8–15, data 0; init_done_o=1 on the 3rd cycle; ready=0 throughout INIT.
- RUN, all 8 valid with distinct addresses 0..7: ready=8'hFF; next cycle we_o=8'hFF with matching addr/data; conflict_cnt_o unchanged.
- RUN, requesters 2 and 5 both at addr 3, prio_ptr=0: ready[2]=1, ready[5]=0; conflict_cnt_o=1; prio_ptr=1; requester 5 is granted the next cycle.
- All 8 requesters continuously valid at addr 7: exactly one grant per cycle, grants rotate 0,1,…,7; every requester is served within 8 cycles.
- flush_i in RUN while requester 0 writes addr 9=8'hA5: we_o[0] issues that write, then 2 INIT cycles rewrite 0; init_done_o drops for 2 cycles, ready stays low.
- Async reset asserted mid-RUN between edges: all outputs go to reset values immediately, without waiting for a clock edge; conflict_cnt_o=0.
